seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 4, SHALL be the pattern length in bits; legal range 2..16.
REQ-002 Parameter RESET_PAT, default 4'b1011, SHALL be the PAT_LEN-bit pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8, SHALL be the match counter width; legal range 1..32.
REQ-004 Derived PW = clog2(PAT_LEN+1) SHALL be the progress width (3 for the defaults).
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 in  input  1  SHALL be the serial data bit.
REQ-008 in_valid  input  1  SHALL qualify in; a bit is accepted only on cycles with in_valid=1.
REQ-009 overlap  input  1  SHALL select the overlap mode (1) or non-overlap mode (0), sampled with each accepted bit.
REQ-010 pat_load  input  1  SHALL load pat_in as the new pattern.
REQ-011 pat_in  input  PAT_LEN  SHALL be the pattern value; pat_in[PAT_LEN-1] is the first bit expected, pat_in[0] the last.
REQ-012 cnt_clear  input  1  SHALL clear match_cnt.
REQ-013 out  output  PW  SHALL be the registered progress: the number of pattern bits currently matched (0..PAT_LEN).
REQ-014 match  output  1  SHALL be a registered one-cycle pulse marking a completed match.
REQ-015 match_cnt  output  CNT_W  SHALL be a registered, saturating count of matches.

Function
REQ-016 The block SHALL be a Moore detector; out, match and match_cnt SHALL update only on a rising clk edge, one cycle after the accepted bit (latency 1).
REQ-017 The block SHALL hold a PAT_LEN-bit history of accepted bits and the progress register P.
REQ-018 On an accepted bit b, the next P SHALL be the largest k (0..PAT_LEN) such that the last k bits of the effective history followed by b equal pattern[PAT_LEN-1 -: k]. This is full prefix-suffix fallback, not a reset to 0 on mismatch.
REQ-019 The effective history SHALL be the bits accepted since the last reset or pat_load, with one exception: when P==PAT_LEN and overlap=0, the effective history SHALL be empty.
REQ-020 match SHALL be 1 in exactly the cycle in which P becomes PAT_LEN, and 0 otherwise.
REQ-021 On cycles with in_valid=0, P, out and the history SHALL hold, and match SHALL be 0.
REQ-022 On each match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 without wrapping.
REQ-023 cnt_clear=1 SHALL set match_cnt to 0 on the next edge; if a match occurs in the same cycle, clear SHALL win (count 0) and match SHALL still pulse.
REQ-024 pat_load=1 SHALL replace the pattern and set P and out to 0 and empty the history; match_cnt SHALL be unchanged.
REQ-025 pat_load and in_valid asserted together: the load SHALL win and the bit SHALL be discarded (match=0).
REQ-026 The pattern register SHALL be stable between loads and SHALL be unaffected by cnt_clear.

Reset
REQ-027 reset=1 SHALL set out=0, match=0, match_cnt=0, the pattern to RESET_PAT and the history to empty, overriding all other inputs in that cycle.
REQ-028 Reset asserted mid-pattern SHALL discard the partial match; the first accepted bit after reset SHALL be evaluated from P=0.

Verification
REQ-029 Defaults, overlap=1, bits 1,0,1,1,0,1,1 -> out 1,2,3,4,2,3,4; match pulses after the 4th and 7th bits; match_cnt=2.
REQ-030 Defaults, overlap=0, bits 1,0,1,1,0,1,1 -> out 1,2,3,4,0,1,1; one match; match_cnt=1.
REQ-031 Defaults, bits 1,1,0,1,1 -> out 1,1,2,3,4 (fallback from 1 to 1 after the second 1); one match.
REQ-032 CNT_W=2, overlap=1, stream 1011 followed by 011 repeated 4 times -> match_cnt 1,2,3,3; cnt_clear on the 5th match -> match_cnt=0 and match=1.
REQ-033 After 1,0,1: pat_load with pat_in=4'b0110 together with in_valid -> out=0, bit dropped; then 0,1,1,0 -> out 1,2,3,4 and match.
REQ-034 Reset asserted after 1,0,1 (out=3) -> out=0, match_cnt=0, pattern=1011; then 1 -> out=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, full prefix-suffix fallback,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_param #(
   parameter int                 PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1011,
   parameter int                 CNT_W     = 8,
   localparam int                PW        = $clog2(PAT_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clear,
   output logic [PW-1:0]      out,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam logic [PW-1:0]    FULL_P   = PW'(PAT_LEN);
   localparam logic [PW-1:0]    HIST_MAX = PW'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [PAT_LEN-1:0] pat_r;
   logic [PAT_LEN-2:0] hist_r;
   logic [PW-1:0]      hlen_r;
   logic [PW-1:0]      prog_r;
   logic               match_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [PAT_LEN-1:0] cand_s;
   logic [PW-1:0]      eff_len_s;
   logic [PW-1:0]      next_p_s;
   logic               take_s;
   logic               hit_s;

   // Largest k such that the last k bits of cand equal the first k pattern bits,
   // limited to k <= len+1 (only len history bits are genuine).
   function automatic logic [PW-1:0] best_prefix(input logic [PAT_LEN-1:0] pat,
                                                 input logic [PAT_LEN-1:0] cand,
                                                 input logic [PW-1:0]      len);
      logic [PW-1:0]      best;
      logic [PAT_LEN-1:0] mask;
      best = '0;
      for (int k = 1; k <= PAT_LEN; k++) begin
         mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
         if ((k <= int'(len) + 1) && ((cand & mask) == ((pat >> (PAT_LEN - k)) & mask)))
            best = PW'(k);
         else
            best = best;
      end
      return best;
   endfunction

   // Next-progress evaluation for the candidate bit.
   always_comb begin
      cand_s    = {hist_r, in};
      take_s    = in_valid && !pat_load;
      if ((prog_r == FULL_P) && !overlap)
         eff_len_s = '0;
      else
         eff_len_s = hlen_r;
      next_p_s  = best_prefix(pat_r, cand_s, eff_len_s);
      hit_s     = take_s && (next_p_s == FULL_P);
   end

   // Pattern, history, progress, match pulse and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_r   <= RESET_PAT;
         hist_r  <= '0;
         hlen_r  <= '0;
         prog_r  <= '0;
         match_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         match_r <= hit_s;
         if (pat_load) begin
            pat_r  <= pat_in;
            hist_r <= '0;
            hlen_r <= '0;
            prog_r <= '0;
         end else if (in_valid) begin
            hist_r <= cand_s[PAT_LEN-2:0];
            hlen_r <= (eff_len_s >= HIST_MAX) ? HIST_MAX : eff_len_s + PW'(1);
            prog_r <= next_p_s;
         end
         if (cnt_clear)
            cnt_r <= '0;
         else if (hit_s && (cnt_r != CNT_MAX))
            cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign out       = prog_r;
   assign match     = match_r;
   assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a CNT_W=2 instance
// sharing the same stimulus.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in = 1'b0;
   logic       in_valid = 1'b0;
   logic       overlap = 1'b1;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'b0000;
   logic       cnt_clear = 1'b0;

   logic [2:0] out_a, out_b;
   logic       match_a, match_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int checks = 0;
   int errors = 0;

   seq_detect_param dut_a (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clear(cnt_clear),
      .out(out_a), .match(match_a), .match_cnt(cnt_a)
   );

   seq_detect_param #(.CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clear(cnt_clear),
      .out(out_b), .match(match_b), .match_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Feed one accepted bit, then check out and match on instance A.
   task automatic feed(input string tag, input logic b, input int eo, input int em);
      in = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("%s out", tag), 32'(out_a), 32'(eo));
      chk($sformatf("%s match", tag), 32'(match_a), 32'(em));
   endtask

   initial begin
      logic [6:0] s7;
      logic [4:0] s5;
      int         eo7 [7];
      int         em7 [7];
      int         eo5 [5];

      // reset overrides a simultaneous valid bit
      in = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      reset = 1'b0;
      chk("rst out", 32'(out_a), 32'd0);
      chk("rst match", 32'(match_a), 32'd0);
      chk("rst cnt", 32'(cnt_a), 32'd0);
      chk("rst cnt_b", 32'(cnt_b), 32'd0);

      // overlap mode, 1011011
      overlap = 1'b1;
      s7 = 7'b1011011;
      eo7 = '{1, 2, 3, 4, 2, 3, 4};
      em7 = '{0, 0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++)
         feed($sformatf("ovl%0d", i), s7[6-i], eo7[i], em7[i]);
      chk("ovl cnt", 32'(cnt_a), 32'd2);
      tick();
      chk("idle out", 32'(out_a), 32'd4);
      chk("idle match", 32'(match_a), 32'd0);

      // non-overlap mode
      do_reset();
      overlap = 1'b0;
      eo7 = '{1, 2, 3, 4, 0, 1, 1};
      em7 = '{0, 0, 0, 1, 0, 0, 0};
      for (int i = 0; i < 7; i++)
         feed($sformatf("nov%0d", i), s7[6-i], eo7[i], em7[i]);
      chk("nov cnt", 32'(cnt_a), 32'd1);

      // fallback 1 -> 1
      do_reset();
      overlap = 1'b1;
      s5 = 5'b11011;
      eo5 = '{1, 1, 2, 3, 4};
      for (int i = 0; i < 5; i++)
         feed($sformatf("fb%0d", i), s5[4-i], eo5[i], (i == 4) ? 1 : 0);

      // saturating 2-bit counter and clear-wins
      do_reset();
      feed("sat0", 1'b1, 1, 0);
      feed("sat1", 1'b0, 2, 0);
      feed("sat2", 1'b1, 3, 0);
      feed("sat3", 1'b1, 4, 1);
      chk("sat cnt_b m1", 32'(cnt_b), 32'd1);
      for (int r = 0; r < 4; r++) begin
         feed($sformatf("rep%0d a", r), 1'b0, 2, 0);
         feed($sformatf("rep%0d b", r), 1'b1, 3, 0);
         if (r == 3) cnt_clear = 1'b1;
         feed($sformatf("rep%0d c", r), 1'b1, 4, 1);
         cnt_clear = 1'b0;
         chk($sformatf("sat cnt_b m%0d", r + 2), 32'(cnt_b), (r == 0) ? 32'd2 : (r == 3) ? 32'd0 : 32'd3);
         chk($sformatf("sat match_b m%0d", r + 2), 32'(match_b), 32'd1);
      end
      chk("clr cnt_a", 32'(cnt_a), 32'd0);

      // pattern load wins over a valid bit
      do_reset();
      feed("ld0", 1'b1, 1, 0);
      feed("ld1", 1'b0, 2, 0);
      feed("ld2", 1'b1, 3, 0);
      pat_in = 4'b0110;
      pat_load = 1'b1;
      in = 1'b0;
      in_valid = 1'b1;
      tick();
      pat_load = 1'b0;
      in_valid = 1'b0;
      chk("ld out", 32'(out_a), 32'd0);
      chk("ld match", 32'(match_a), 32'd0);
      feed("np0", 1'b0, 1, 0);
      feed("np1", 1'b1, 2, 0);
      feed("np2", 1'b1, 3, 0);
      feed("np3", 1'b0, 4, 1);
      chk("np cnt", 32'(cnt_a), 32'd1);
      pat_in = 4'b1011;
      pat_load = 1'b1;
      tick();
      pat_load = 1'b0;
      chk("ld keeps cnt", 32'(cnt_a), 32'd1);
      chk("ld2 out", 32'(out_a), 32'd0);

      // reset mid-pattern after loading a different pattern
      pat_in = 4'b0110;
      pat_load = 1'b1;
      tick();
      pat_load = 1'b0;
      pat_in = 4'b1011;
      pat_load = 1'b1;
      tick();
      pat_load = 1'b0;
      feed("mr0", 1'b1, 1, 0);
      feed("mr1", 1'b0, 2, 0);
      feed("mr2", 1'b1, 3, 0);
      pat_in = 4'b0110;
      pat_load = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pat_load = 1'b0;
      chk("mr out", 32'(out_a), 32'd0);
      chk("mr cnt", 32'(cnt_a), 32'd0);
      chk("mr match", 32'(match_a), 32'd0);
      feed("mr after", 1'b1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
